traffic_sensor_aggregator: RTL and testbench

//  Upstream conditioning stage for the turn controller. Synchronises raw vehicle

---
 rtl/traffic_sensor_aggregator.sv | 180 ++++++++++++++++++
 tb/tb_traffic_sensor_aggregator.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/traffic_sensor_aggregator.sv
// Input conditioning for the turn controller: synchronisers, windowed vehicle counts,
// button debounce FSMs and police request conditioning. Optional macro: POLICE_HOLD_EN.
module traffic_sensor_aggregator #(
    parameter int WINDOW_CYCLES   = 20,
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int POLICE_HOLD     = 6
) (
    input  logic       clock,
    input  logic       reset_N,
    input  logic       car_Sensor_0,
    input  logic       car_Sensor_1,
    input  logic       ped_Button_Hori,
    input  logic       ped_Button_Vert,
    input  logic       police_Request,
    output logic [3:0] traffic_Street_0,
    output logic [3:0] traffic_Street_1,
    output logic       ped_Hori_Interrupt,
    output logic       ped_Vert_Interrupt,
    output logic       police_Interrupt,
    output logic       window_Done,
    output logic       log_Enable,
    output logic       log_Read_Write
);

    localparam int              WC_W    = $clog2(WINDOW_CYCLES);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(WINDOW_CYCLES - 1);
    localparam logic [2:0]      DB_LAST = 3'(DEBOUNCE_CYCLES);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ARMING    = 2'd1;
    localparam logic [1:0] ACTIVE    = 2'd2;
    localparam logic [1:0] RELEASING = 2'd3;

    if (WINDOW_CYCLES < 2 || DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 7 || POLICE_HOLD < 1) begin : g_bad_param
        $error("traffic_sensor_aggregator: parameter out of range");
    end

    function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic inc);
        return (inc && v != 4'hF) ? v + 4'd1 : v;
    endfunction

    // bit order: car0, car1, ped hori, ped vert, police
    logic [4:0]      raw_p0, raw_p1;
    logic [1:0]      car_p2;
    logic [1:0]      car_rise;
    logic [3:0]      acc0, acc1;
    logic [WC_W-1:0] wcnt;
    logic            win_last;
    logic [1:0]      ped_int;

    logic [1:0] btn_st      [2];
    logic [1:0] btn_st_nxt  [2];
    logic [2:0] btn_cnt     [2];
    logic [2:0] btn_cnt_nxt [2];

    assign car_rise = raw_p1[1:0] & ~car_p2;
    assign win_last = (wcnt == WC_LAST);

    // Stage p0/p1: two-flop synchronisers; p2: previous synced sensor level for edge detect
    always_ff @(posedge clock) begin
        if (!reset_N) begin
            raw_p0 <= '0;
            raw_p1 <= '0;
            car_p2 <= '0;
        end else begin
            raw_p0 <= {police_Request, ped_Button_Vert, ped_Button_Hori, car_Sensor_1, car_Sensor_0};
            raw_p1 <= raw_p0;
            car_p2 <= raw_p1[1:0];
        end
    end

    // A rise on the final window cycle belongs to the window being closed
    always_ff @(posedge clock) begin
        if (!reset_N) begin
            wcnt             <= '0;
            acc0             <= '0;
            acc1             <= '0;
            traffic_Street_0 <= '0;
            traffic_Street_1 <= '0;
            window_Done      <= 1'b0;
        end else begin
            window_Done <= win_last;
            if (win_last) begin
                wcnt             <= '0;
                acc0             <= '0;
                acc1             <= '0;
                traffic_Street_0 <= sat_inc(acc0, car_rise[0]);
                traffic_Street_1 <= sat_inc(acc1, car_rise[1]);
            end else begin
                wcnt <= wcnt + WC_W'(1);
                acc0 <= sat_inc(acc0, car_rise[0]);
                acc1 <= sat_inc(acc1, car_rise[1]);
            end
        end
    end

    assign log_Enable     = window_Done;
    assign log_Read_Write = window_Done;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            btn_st_nxt[i]  = btn_st[i];
            btn_cnt_nxt[i] = btn_cnt[i];
            case (btn_st[i])
                IDLE: if (raw_p1[2+i]) begin
                    btn_st_nxt[i]  = (DEBOUNCE_CYCLES == 1) ? ACTIVE : ARMING;
                    btn_cnt_nxt[i] = 3'd1;
                end
                ARMING: if (!raw_p1[2+i]) begin
                    btn_st_nxt[i]  = IDLE;
                end else begin
                    btn_cnt_nxt[i] = btn_cnt[i] + 3'd1;
                    if (btn_cnt[i] + 3'd1 == DB_LAST) btn_st_nxt[i] = ACTIVE;
                end
                ACTIVE: if (!raw_p1[2+i]) begin
                    btn_st_nxt[i]  = (DEBOUNCE_CYCLES == 1) ? IDLE : RELEASING;
                    btn_cnt_nxt[i] = 3'd1;
                end
                RELEASING: if (raw_p1[2+i]) begin
                    btn_st_nxt[i]  = ACTIVE;
                end else begin
                    btn_cnt_nxt[i] = btn_cnt[i] + 3'd1;
                    if (btn_cnt[i] + 3'd1 == DB_LAST) btn_st_nxt[i] = IDLE;
                end
                default: btn_st_nxt[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_N) begin
            for (int i = 0; i < 2; i++) begin
                btn_st[i]  <= IDLE;
                btn_cnt[i] <= '0;
            end
            ped_int <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                btn_st[i]  <= btn_st_nxt[i];
                btn_cnt[i] <= btn_cnt_nxt[i];
                ped_int[i] <= (btn_st_nxt[i] == ACTIVE) || (btn_st_nxt[i] == RELEASING);
            end
        end
    end

    assign ped_Hori_Interrupt = ped_int[0];
    assign ped_Vert_Interrupt = ped_int[1];

`ifdef POLICE_HOLD_EN
    localparam int PH_W = $clog2(POLICE_HOLD + 1);

    logic            pol_p2;
    logic [PH_W-1:0] hold_cnt, hold_nxt;

    // A fresh request edge restarts the hold even if one is already running
    always_comb begin
        if (raw_p1[4] && !pol_p2)  hold_nxt = PH_W'(POLICE_HOLD);
        else if (hold_cnt != '0)   hold_nxt = hold_cnt - PH_W'(1);
        else                       hold_nxt = '0;
    end

    always_ff @(posedge clock) begin
        if (!reset_N) begin
            pol_p2           <= 1'b0;
            hold_cnt         <= '0;
            police_Interrupt <= 1'b0;
        end else begin
            pol_p2           <= raw_p1[4];
            hold_cnt         <= hold_nxt;
            police_Interrupt <= (hold_nxt != '0) || raw_p1[4];
        end
    end
`else
    always_ff @(posedge clock) begin
        if (!reset_N) police_Interrupt <= 1'b0;
        else          police_Interrupt <= raw_p1[4];
    end
`endif

endmodule

// File: tb/tb_traffic_sensor_aggregator.sv
// Directed bench for traffic_sensor_aggregator: default instance plus a 40-cycle window
// instance for saturation and window-boundary counting.
module tb_traffic_sensor_aggregator;

    logic clock = 1'b0;
    logic reset_N;
    logic a_car0, a_car1, a_hori, a_vert, a_pol;
    logic b_car0, b_car1;

    logic [3:0] a_ts0, a_ts1, b_ts0, b_ts1;
    logic a_ph, a_pv, a_pi, a_done, a_le, a_lrw;
    logic b_ph, b_pv, b_pi, b_done, b_le, b_lrw;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    traffic_sensor_aggregator dut_a (
        .clock(clock), .reset_N(reset_N),
        .car_Sensor_0(a_car0), .car_Sensor_1(a_car1),
        .ped_Button_Hori(a_hori), .ped_Button_Vert(a_vert), .police_Request(a_pol),
        .traffic_Street_0(a_ts0), .traffic_Street_1(a_ts1),
        .ped_Hori_Interrupt(a_ph), .ped_Vert_Interrupt(a_pv), .police_Interrupt(a_pi),
        .window_Done(a_done), .log_Enable(a_le), .log_Read_Write(a_lrw)
    );

    traffic_sensor_aggregator #(.WINDOW_CYCLES(40)) dut_b (
        .clock(clock), .reset_N(reset_N),
        .car_Sensor_0(b_car0), .car_Sensor_1(b_car1),
        .ped_Button_Hori(1'b0), .ped_Button_Vert(1'b0), .police_Request(1'b0),
        .traffic_Street_0(b_ts0), .traffic_Street_1(b_ts1),
        .ped_Hori_Interrupt(b_ph), .ped_Vert_Interrupt(b_pv), .police_Interrupt(b_pi),
        .window_Done(b_done), .log_Enable(b_le), .log_Read_Write(b_lrw)
    );

    typedef struct {
        int         n0;
        int         n1;
        logic [3:0] e0;
        logic [3:0] e1;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulses(input bit on_b, input int n0, input int n1);
        int n = (n0 > n1) ? n0 : n1;
        for (int i = 0; i < n; i++) begin
            if (on_b) begin b_car0 = (i < n0); b_car1 = (i < n1); end
            else      begin a_car0 = (i < n0); a_car1 = (i < n1); end
            tick();
            if (on_b) begin b_car0 = 1'b0; b_car1 = 1'b0; end
            else      begin a_car0 = 1'b0; a_car1 = 1'b0; end
            tick();
        end
    endtask

    task automatic wait_done(input bit on_b, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (((on_b ? b_done : a_done) == 1'b0) && n < 60);
        chk(on_b ? "b_strobe_seen" : "a_strobe_seen", 32'(on_b ? b_done : a_done), 1);
    endtask

    task automatic chk_a_zero(input string tag);
        chk({tag, "_ts0"}, 32'(a_ts0), 0);
        chk({tag, "_ts1"}, 32'(a_ts1), 0);
        chk({tag, "_ped_hori"}, 32'(a_ph), 0);
        chk({tag, "_ped_vert"}, 32'(a_pv), 0);
        chk({tag, "_police"}, 32'(a_pi), 0);
        chk({tag, "_done"}, 32'(a_done), 0);
        chk({tag, "_log_en"}, 32'(a_le), 0);
        chk({tag, "_log_rw"}, 32'(a_lrw), 0);
    endtask

    initial begin
        int n;
        int m;
        bit seen;
        logic exp;

        vecs[0] = '{7, 0, 4'd7, 4'd0};
        vecs[1] = '{0, 7, 4'd0, 4'd7};
        vecs[2] = '{3, 5, 4'd3, 4'd5};
        vecs[3] = '{8, 8, 4'd8, 4'd8};
        vecs[4] = '{0, 0, 4'd0, 4'd0};
        vecs[5] = '{1, 6, 4'd1, 4'd6};

        reset_N = 1'b0;
        {a_car0, a_car1, a_hori, a_vert, a_pol, b_car0, b_car1} = '0;
        repeat (3) tick();
        chk_a_zero("reset");
        reset_N = 1'b1;
        wait_done(1'b0, n);
        chk("first_strobe_latency", 32'(n), 20);

        foreach (vecs[v]) begin
            pulses(1'b0, vecs[v].n0, vecs[v].n1);
            wait_done(1'b0, n);
            chk($sformatf("vec%0d_ts0", v), 32'(a_ts0), 32'(vecs[v].e0));
            chk($sformatf("vec%0d_ts1", v), 32'(a_ts1), 32'(vecs[v].e1));
            chk($sformatf("vec%0d_log_en", v), 32'(a_le), 1);
            chk($sformatf("vec%0d_log_rw", v), 32'(a_lrw), 1);
            tick();
            chk($sformatf("vec%0d_done_one_cycle", v), 32'(a_done), 0);
            chk($sformatf("vec%0d_ts0_hold", v), 32'(a_ts0), 32'(vecs[v].e0));
            chk($sformatf("vec%0d_ts1_hold", v), 32'(a_ts1), 32'(vecs[v].e1));
        end

        // short press must be rejected
        a_vert = 1'b1;
        tick(); tick();
        a_vert = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (a_pv) seen = 1'b1;
        end
        chk("ped_vert_short_press", 32'(seen), 0);

        a_vert = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (k == 6) a_vert = 1'b0;
            exp = (k >= 5 && k <= 10);
            chk($sformatf("ped_vert_k%0d", k), 32'(a_pv), 32'(exp));
            if (k == 7) chk("ped_hori_independent", 32'(a_ph), 0);
        end

        a_pol = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 1) a_pol = 1'b0;
`ifdef POLICE_HOLD_EN
            exp = (k >= 3 && k <= 8);
`else
            exp = (k == 3);
`endif
            chk($sformatf("police_k%0d", k), 32'(a_pi), 32'(exp));
        end

        // two-clock reset while a button is held and a window is partly counted
        wait_done(1'b0, n);
        a_hori = 1'b1;
        pulses(1'b0, 3, 0);
        chk("ped_hori_active_before_reset", 32'(a_ph), 1);
        reset_N = 1'b0;
        a_hori = 1'b0;
        tick(); tick();
        chk_a_zero("mid_reset");
        reset_N = 1'b1;
        pulses(1'b0, 4, 0);
        wait_done(1'b0, n);
        chk("strobe_after_mid_reset", 32'(n + 8), 20);
        chk("partial_window_discarded", 32'(a_ts0), 4);

        // one-clock reset discards earlier pulses too
        pulses(1'b0, 3, 0);
        reset_N = 1'b0;
        tick();
        reset_N = 1'b1;
        pulses(1'b0, 4, 0);
        wait_done(1'b0, n);
        chk("one_clock_reset_ts0", 32'(a_ts0), 4);

        wait_done(1'b1, n);
        pulses(1'b1, 0, 18);
        wait_done(1'b1, n);
        chk("b_saturate_ts1", 32'(b_ts1), 15);
        chk("b_saturate_ts0", 32'(b_ts0), 0);
        pulses(1'b1, 0, 2);
        wait_done(1'b1, n);
        chk("b_after_sat_ts1", 32'(b_ts1), 2);
        // raw high timed so its synced rise lands on the closing cycle of this window
        repeat (37) tick();
        b_car1 = 1'b1;
        tick();
        b_car1 = 1'b0;
        m = 0;
        while (!b_done && m < 10) begin
            tick();
            m++;
        end
        chk("b_last_cycle_strobe_at", 32'(m), 2);
        chk("b_last_cycle_counted", 32'(b_ts1), 1);
        wait_done(1'b1, n);
        chk("b_last_cycle_not_recounted", 32'(b_ts1), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
